// File: rtl/portal_arb_pkg.sv
// Shared types and sizing helpers for the portal indication arbiter and its
// round-robin picker.
package portal_arb_pkg;
  localparam int N_SRC_MAX   = 16;
  localparam int MSG_COUNT_W = 16;

  // Source id width; a single source still gets one tag bit.
  function automatic int src_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Beat as seen by software at the default 32-bit payload width.
  typedef struct packed {
    logic [$clog2(N_SRC_MAX)-1:0] src;
    logic                         last;
    logic [31:0]                  v;
  } ind_beat_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the search starts just after rr_last,
// so the most recent winner has the lowest priority.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);
  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_last) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = W'(idx);
      end
    end
  end
endmodule

// File: rtl/portal_ind_arbiter.sv
// Message-atomic round-robin arbiter: N_SRC indication sources share one
// portal indication pipe, and each beat is tagged with its source id.
module portal_ind_arbiter import portal_arb_pkg::*; #(
  parameter  int N_SRC     = 4,
  parameter  int WIDTH     = 32,
  parameter  int MAX_BEATS = 16,
  localparam int SRC_W     = src_w(N_SRC)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   arb_enable,
  input  logic [N_SRC-1:0]       in_enq__ENA,
  input  logic [N_SRC*WIDTH-1:0] in_enq_v,
  input  logic [N_SRC-1:0]       in_enq_last,
  output logic [N_SRC-1:0]       in_enq__RDY,
  output logic                   out_enq__ENA,
  output logic [WIDTH-1:0]       out_enq_v,
  output logic                   out_enq_last,
  output logic [SRC_W-1:0]       out_enq_src,
  input  logic                   out_enq__RDY,
  output logic [MSG_COUNT_W-1:0] msg_count,
  output logic                   err_overrun
);
  localparam int              CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state;
  logic [SRC_W-1:0] owner, rr_last, cur;
  logic [CNT_W-1:0] beat_cnt;
  logic [N_SRC-1:0] pick_gnt, sel;
  logic [SRC_W-1:0] pick_idx;
  logic             xfer;

  rr_pick #(.N(N_SRC), .W(SRC_W)) u_pick (
    .req     (in_enq__ENA & {N_SRC{arb_enable}}),
    .rr_last (rr_last),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // While locked only the owner is eligible, whether or not it is requesting.
  always_comb begin
    cur          = (state == LOCKED) ? owner : pick_idx;
    sel          = '0;
    out_enq__ENA = 1'b0;
    out_enq_v    = '0;
    out_enq_last = 1'b0;
    out_enq_src  = '0;
    if (state == LOCKED) begin
      for (int i = 0; i < N_SRC; i++)
        if (owner == SRC_W'(i)) sel[i] = 1'b1;
      out_enq__ENA = |(sel & in_enq__ENA);
    end else begin
      sel          = pick_gnt;
      out_enq__ENA = |pick_gnt;
    end
    for (int i = 0; i < N_SRC; i++)
      if (sel[i] && out_enq__ENA) begin
        out_enq_v    = in_enq_v[i*WIDTH +: WIDTH];
        out_enq_last = in_enq_last[i];
      end
    if (out_enq__ENA) out_enq_src = cur;
    in_enq__RDY = sel & {N_SRC{out_enq__RDY}};
  end

  assign xfer = out_enq__ENA & out_enq__RDY;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      owner       <= '0;
      rr_last     <= SRC_W'(N_SRC - 1);
      beat_cnt    <= '0;
      msg_count   <= '0;
      err_overrun <= 1'b0;
    end else if (xfer) begin
      // beat_cnt saturates, so reaching CNT_MAX while locked means this beat overruns
      if (state == LOCKED && beat_cnt == CNT_MAX) err_overrun <= 1'b1;
      if (out_enq_last) begin
        state     <= IDLE;
        rr_last   <= cur;
        msg_count <= msg_count + MSG_COUNT_W'(1);
        beat_cnt  <= '0;
      end else begin
        state <= LOCKED;
        owner <= cur;
        if (state == IDLE)          beat_cnt <= CNT_W'(1);
        else if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_portal_ind_arbiter.sv
// Directed bench for portal_ind_arbiter: queue-driven sources, a message-level
// reference model checked every cycle, and literal grant-order expectations.
module tb_portal_ind_arbiter;
  localparam int N = 4, W = 32, MB = 4;

  logic           CLK = 1'b0;
  logic           nRST, arb_enable, out_rdy;
  logic [N-1:0]   ena, last, rdy;
  logic [N*W-1:0] vbus;
  logic           out_ena, out_last, err;
  logic [W-1:0]   out_v;
  logic [1:0]     out_src;
  logic [15:0]    msg_count;

  portal_ind_arbiter #(.N_SRC(N), .WIDTH(W), .MAX_BEATS(MB)) dut (
    .CLK(CLK), .nRST(nRST), .arb_enable(arb_enable),
    .in_enq__ENA(ena), .in_enq_v(vbus), .in_enq_last(last), .in_enq__RDY(rdy),
    .out_enq__ENA(out_ena), .out_enq_v(out_v), .out_enq_last(out_last),
    .out_enq_src(out_src), .out_enq__RDY(out_rdy),
    .msg_count(msg_count), .err_overrun(err)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Source queues: {last, v}; a beat pops once it is accepted.
  logic [32:0] q[N][$];
  task automatic push(input int s, input logic [31:0] v, input logic l);
    q[s].push_back({l, v});
  endtask

  initial begin
    logic [N-1:0] xf;
    ena = '0; last = '0; vbus = '0;
    forever begin
      @(posedge CLK);
      for (int i = 0; i < N; i++) xf[i] = nRST && ena[i] && rdy[i];
      #1;
      for (int i = 0; i < N; i++) begin
        if (xf[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (q[i].size() > 0) begin
          ena[i] = 1'b1; vbus[i*W +: W] = q[i][0][31:0]; last[i] = q[i][0][32];
        end else begin
          ena[i] = 1'b0; vbus[i*W +: W] = '0; last[i] = 1'b0;
        end
      end
    end
  end

  // Reference model: message ownership and service order from the arbitration rules.
  typedef struct { int src; logic [31:0] v; } ent_t;
  ent_t lg[$];
  int lp = 0;
  int m_owner = -1, m_last = N - 1, m_beats = 0, m_msgs = 0;
  logic m_err = 1'b0;

  always @(negedge CLK) begin
    int w; logic xe, el; logic [N-1:0] er; logic [31:0] ev;
    if (!nRST) begin
      m_owner = -1; m_last = N - 1; m_beats = 0; m_msgs = 0; m_err = 1'b0;
    end else begin
      chk("msg_count", msg_count, m_msgs);
      chk("err_overrun", err, m_err);
      w = -1;
      if (m_owner >= 0) w = m_owner;
      else if (arb_enable)
        for (int k = 1; k <= N; k++)
          if (w < 0 && ena[(m_last + k) % N]) w = (m_last + k) % N;
      xe = (w >= 0) && ena[w];
      er = (w >= 0 && out_rdy) ? N'(1 << w) : '0;
      ev = xe ? vbus[w*W +: W] : '0;
      el = xe ? last[w] : 1'b0;
      chk("out_ena", out_ena, xe);
      chk("in_rdy", rdy, er);
      chk("out_v", out_v, ev);
      chk("out_last", out_last, el);
      chk("out_src", out_src, xe ? w : 0);
      if (out_ena && out_rdy) lg.push_back('{int'(out_src), out_v});
      if (xe && out_rdy) begin
        m_beats++;
        if (m_beats > MB) m_err = 1'b1;
        if (el) begin
          m_msgs = (m_msgs + 1) % 65536; m_last = w; m_owner = -1; m_beats = 0;
        end else m_owner = w;
      end
    end
  end

  task automatic exp_beat(input string nm, input int s, input logic [31:0] v);
    if (lp < lg.size()) begin
      chk({nm, "_src"}, lg[lp].src, s);
      chk({nm, "_v"}, lg[lp].v, v);
    end else chk({nm, "_missing"}, 1, 0);
    lp++;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && n < 200) begin
      @(posedge CLK); n++;
    end
    @(posedge CLK);
    @(negedge CLK);
    if (n >= 200) chk({nm, "_timeout"}, n, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; arb_enable = 1'b1; out_rdy = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_msg_count", msg_count, 0);
    chk("rst_err", err, 0);
    chk("rst_out_ena", out_ena, 0);
    @(posedge CLK); #1 nRST = 1'b1;

    // 1: four single-beat requesters, served 0,1,2,3 then 0 again
    @(negedge CLK);
    push(0, 32'h100, 1); push(0, 32'h101, 1);
    push(1, 32'h110, 1); push(2, 32'h120, 1); push(3, 32'h130, 1);
    drain("t1");
    exp_beat("t1a", 0, 32'h100); exp_beat("t1b", 1, 32'h110); exp_beat("t1c", 2, 32'h120);
    exp_beat("t1d", 3, 32'h130); exp_beat("t1e", 0, 32'h101);
    chk("t1_msg_count", msg_count, 5);

    // 2: src1 3-beat message holds off src2
    push(1, 32'h201, 0); push(1, 32'h202, 0); push(1, 32'h203, 1); push(2, 32'h301, 1);
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    chk("t2_rdy_locked", rdy, 4'b0010);
    drain("t2");
    exp_beat("t2a", 1, 32'h201); exp_beat("t2b", 1, 32'h202);
    exp_beat("t2c", 1, 32'h203); exp_beat("t2d", 2, 32'h301);
    chk("t2_msg_count", msg_count, 7);

    // 3: downstream stall for 5 cycles mid-message
    push(3, 32'h401, 0); push(3, 32'h402, 0); push(3, 32'h403, 1);
    @(posedge CLK); @(posedge CLK); #1 out_rdy = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      chk("t3_stall_v", out_v, 32'h402);
      chk("t3_stall_rdy", rdy, 0);
    end
    @(posedge CLK); #1 out_rdy = 1'b1;
    drain("t3");
    exp_beat("t3a", 3, 32'h401); exp_beat("t3b", 3, 32'h402); exp_beat("t3c", 3, 32'h403);
    chk("t3_msg_count", msg_count, 8);

    // 4: disable mid-message; locked message finishes, then no grants
    push(3, 32'h501, 0); push(3, 32'h502, 1);
    @(posedge CLK); @(posedge CLK); #1 arb_enable = 1'b0;
    @(negedge CLK);
    push(0, 32'h511, 1); push(1, 32'h521, 1);
    repeat (3) begin
      @(negedge CLK);
      chk("t4_disabled_ena", out_ena, 0);
    end
    @(posedge CLK); #1 arb_enable = 1'b1;
    drain("t4");
    exp_beat("t4a", 3, 32'h501); exp_beat("t4b", 3, 32'h502);
    exp_beat("t4c", 0, 32'h511); exp_beat("t4d", 1, 32'h521);
    chk("t4_msg_count", msg_count, 11);

    // 5: 6-beat message against MAX_BEATS=4
    chk("t5_err_before", err, 0);
    for (int i = 1; i <= 6; i++) push(0, 32'h600 + i, i == 6);
    drain("t5");
    for (int i = 1; i <= 6; i++) exp_beat("t5", 0, 32'h600 + i);
    chk("t5_err_after", err, 1);
    chk("t5_msg_count", msg_count, 12);

    // 6: reset while src2 is locked after beat 2 of 4
    for (int i = 1; i <= 4; i++) push(2, 32'h800 + i, i == 4);
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b0;
    #1;
    chk("t6_rst_msg_count", msg_count, 0);
    chk("t6_rst_err", err, 0);
    @(negedge CLK);
    for (int i = 0; i < N; i++) q[i].delete();
    push(0, 32'h701, 1); push(2, 32'h702, 1);
    @(posedge CLK); @(posedge CLK); #1 nRST = 1'b1;
    drain("t6");
    exp_beat("t6a", 2, 32'h801); exp_beat("t6b", 2, 32'h802);
    exp_beat("t6c", 0, 32'h701); exp_beat("t6d", 2, 32'h702);
    chk("t6_msg_count", msg_count, 2);
    chk("t6_log_len", lg.size(), lp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
